// File: rtl/slc3_io_responder_if.sv
// rtl/slc3_io_responder_if.sv - CPU memory bus and PAUSE handshake bundle for the SLC-3 I/O responder
//  master : CPU/controller side, drives ADDR, Data_from_CPU, MEM_OE, MEM_WE, pause_req, LED_val
//  slave  : responder side, drives Data_to_CPU, io_sel, pause_done
interface slc3_io_responder_if;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic        MEM_OE;        // active-low read enable
  logic        MEM_WE;        // active-low write enable
  logic [15:0] Data_to_CPU;
  logic        io_sel;
  logic        pause_req;
  logic [9:0]  LED_val;
  logic        pause_done;

  modport master (
    output ADDR, Data_from_CPU, MEM_OE, MEM_WE, pause_req, LED_val,
    input  Data_to_CPU, io_sel, pause_done
  );

  modport slave (
    input  ADDR, Data_from_CPU, MEM_OE, MEM_WE, pause_req, LED_val,
    output Data_to_CPU, io_sel, pause_done
  );
endinterface

// File: rtl/slc3_io_responder.sv
// rtl/slc3_io_responder.sv - SLC-3 memory-mapped switch/HEX port and PAUSE/Continue handshake
//  Clk        in   system clock, rising edge
//  Reset_ah   in   asynchronous active-high reset
//  SW         in   raw switches (asynchronous), read back at IO_ADDR
//  Continue   in   raw active-low Continue button (asynchronous)
//  LED        out  pause code captured when a pause request is accepted
//  HEX0..HEX3 out  active-low 7-segment digits of the last word written to IO_ADDR
//  bus        slave side of the CPU bus / PAUSE handshake interface
module slc3_io_responder #(
  parameter logic [15:0] IO_ADDR         = 16'hFFFF,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Reset_ah,
  input  logic [9:0]        SW,
  input  logic              Continue,
  output logic [9:0]        LED,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  slc3_io_responder_if.slave bus
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] WAIT_PRESS   = 2'd1;
  localparam logic [1:0] WAIT_RELEASE = 2'd2;
  localparam logic [1:0] DONE         = 2'd3;

  logic [SYNC_STAGES-1:0][9:0] sw_pipe;
  logic [SYNC_STAGES-1:0]      cont_pipe;
  logic [9:0]                  sw_synced;
  logic                        cont_synced;
  logic                        cont_db;
  logic [CNT_W-1:0]            db_cnt;
  logic [15:0]                 hex_reg;
  logic [1:0]                  state;
  logic                        sel;

  // Synchronisers: element 0 takes the raw pin, the last element is the usable value.
  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      sw_pipe   <= '0;
      cont_pipe <= '0;
    end else begin
      sw_pipe   <= {sw_pipe[SYNC_STAGES-2:0], SW};
      cont_pipe <= {cont_pipe[SYNC_STAGES-2:0], Continue};
    end
  end

  assign sw_synced   = sw_pipe[SYNC_STAGES-1];
  assign cont_synced = cont_pipe[SYNC_STAGES-1];

  // Debounce: the accepted level only follows the synced button after
  // DEBOUNCE_CYCLES consecutive samples that disagree with it.
  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      cont_db <= 1'b1;
      db_cnt  <= '0;
    end else if (cont_synced == cont_db) begin
      db_cnt  <= '0;
    end else if (db_cnt == CNT_LAST) begin
      cont_db <= ~cont_db;
      db_cnt  <= '0;
    end else begin
      db_cnt  <= db_cnt + 1'b1;
    end
  end

  assign sel             = (bus.ADDR == IO_ADDR);
  assign bus.io_sel      = sel;
  assign bus.Data_to_CPU = (sel && !bus.MEM_OE) ? {6'b0, sw_synced} : 16'h0000;

  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      hex_reg <= 16'h0000;
    end else if (sel && !bus.MEM_WE) begin
      hex_reg <= bus.Data_from_CPU;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign HEX0 = seg7(hex_reg[3:0]);
  assign HEX1 = seg7(hex_reg[7:4]);
  assign HEX2 = seg7(hex_reg[11:8]);
  assign HEX3 = seg7(hex_reg[15:12]);

  // PAUSE handshake. Working from the debounced level means a button already
  // held at request time skips WAIT_PRESS but still needs a real release.
  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      state          <= IDLE;
      LED            <= 10'h000;
      bus.pause_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pause_req) begin
            LED   <= bus.LED_val;
            state <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (!bus.pause_req)  state <= IDLE;
          else if (!cont_db)   state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (!bus.pause_req) begin
            state <= IDLE;
          end else if (cont_db) begin
            state          <= DONE;
            bus.pause_done <= 1'b1;
          end
        end
        default: begin
          if (!bus.pause_req) begin
            state          <= IDLE;
            bus.pause_done <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_io_responder.sv
// tb/tb_slc3_io_responder.sv - directed bench with a reference model for slc3_io_responder
module tb_slc3_io_responder;

  localparam logic [15:0] IO_ADDR = 16'hFFFF;
  localparam int          S       = 2;
  localparam int          D       = 4;

  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic       Clk;
  logic       Reset_ah;
  logic [9:0] SW;
  logic       Continue;
  logic [9:0] LED;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;

  slc3_io_responder_if bus ();

  slc3_io_responder #(
    .IO_ADDR        (IO_ADDR),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .Clk     (Clk),
    .Reset_ah(Reset_ah),
    .SW      (SW),
    .Continue(Continue),
    .LED     (LED),
    .HEX0    (HEX0),
    .HEX1    (HEX1),
    .HEX2    (HEX2),
    .HEX3    (HEX3),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: switch history, button history with a run-length
  // debounce, the last written word and the pause handshake progress.
  logic [9:0]  sw_q[$];
  logic        c_q[$];
  logic        m_db;
  int          m_run;
  logic [15:0] m_hex;
  logic [9:0]  m_led;
  logic        m_active, m_pressed, m_done;

  task automatic model_reset();
    sw_q.delete();
    c_q.delete();
    for (int i = 0; i < S; i++) begin
      sw_q.push_back(10'h000);
      c_q.push_back(1'b0);
    end
    m_db      = 1'b1;
    m_run     = 0;
    m_hex     = 16'h0000;
    m_led     = 10'h000;
    m_active  = 1'b0;
    m_pressed = 1'b0;
    m_done    = 1'b0;
  endtask

  task automatic model_step();
    logic c_now;
    if (Reset_ah) begin
      model_reset();
      return;
    end
    c_now = c_q[S-1];
    if (!m_active) begin
      if (bus.pause_req) begin
        m_active  = 1'b1;
        m_pressed = 1'b0;
        m_done    = 1'b0;
        m_led     = bus.LED_val;
      end
    end else if (!bus.pause_req) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else if (!m_pressed) begin
      if (!m_db) m_pressed = 1'b1;
    end else if (!m_done) begin
      if (m_db) m_done = 1'b1;
    end
    if (c_now == m_db) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == D) begin
        m_db  = ~m_db;
        m_run = 0;
      end
    end
    if (bus.ADDR == IO_ADDR && !bus.MEM_WE) m_hex = bus.Data_from_CPU;
    sw_q.push_front(SW);
    void'(sw_q.pop_back());
    c_q.push_front(Continue);
    void'(c_q.pop_back());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clk or posedge Reset_ah);
      model_step();
    end
  end

  initial begin
    forever begin
      logic [15:0] exp_data;
      @(negedge Clk);
      exp_data = (bus.ADDR == IO_ADDR && !bus.MEM_OE) ? {6'b0, sw_q[S-1]} : 16'h0000;
      check("model_data", {16'h0, bus.Data_to_CPU}, {16'h0, exp_data});
      check("model_io_sel", {31'h0, bus.io_sel}, {31'h0, bus.ADDR == IO_ADDR});
      check("model_hex", {4'h0, HEX3, HEX2, HEX1, HEX0},
            {4'h0, SEG[m_hex[15:12]], SEG[m_hex[11:8]], SEG[m_hex[7:4]], SEG[m_hex[3:0]]});
      check("model_led", {22'h0, LED}, {22'h0, m_led});
      check("model_pause_done", {31'h0, bus.pause_done}, {31'h0, m_done});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  initial begin
    Reset_ah          = 1'b1;
    SW                = 10'h000;
    Continue          = 1'b1;
    bus.ADDR          = 16'h0000;
    bus.Data_from_CPU = 16'h0000;
    bus.MEM_OE        = 1'b1;
    bus.MEM_WE        = 1'b1;
    bus.pause_req     = 1'b0;
    bus.LED_val       = 10'h000;
    tick(3);
    Reset_ah = 1'b0;
    #1;
    check("reset_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});
    check("reset_led", {22'h0, LED}, 32'h0);
    check("reset_pause_done", {31'h0, bus.pause_done}, 32'h0);
    check("reset_data", {16'h0, bus.Data_to_CPU}, 32'h0);
    tick(4);

    // switch read path
    SW = 10'h00B; bus.ADDR = 16'hFFFF; bus.MEM_OE = 1'b0;
    tick(2);
    check("sw_read_00b", {16'h0, bus.Data_to_CPU}, 32'h000B);
    SW = 10'h145;
    tick(1);
    check("sw_one_edge", {16'h0, bus.Data_to_CPU}, 32'h000B);
    tick(1);
    check("sw_two_edges", {16'h0, bus.Data_to_CPU}, 32'h0145);
    bus.ADDR = 16'hFFFE;
    #1;
    check("sw_other_addr", {16'h0, bus.Data_to_CPU}, 32'h0000);
    check("io_sel_other", {31'h0, bus.io_sel}, 32'h0);
    bus.MEM_OE = 1'b1;

    // HEX write path
    bus.ADDR = 16'hFFFF; bus.Data_from_CPU = 16'h1234; bus.MEM_WE = 1'b0;
    tick(1);
    bus.MEM_WE = 1'b1;
    check("hex_1234", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h79, 7'h24, 7'h30, 7'h19});
    bus.ADDR = 16'hFFFE; bus.Data_from_CPU = 16'hABCD; bus.MEM_WE = 1'b0;
    tick(1);
    bus.MEM_WE = 1'b1;
    check("hex_other_addr", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h79, 7'h24, 7'h30, 7'h19});
    bus.ADDR = 16'hFFFF; bus.Data_from_CPU = 16'h00F0; bus.MEM_WE = 1'b0; bus.MEM_OE = 1'b0;
    tick(1);
    check("rw_both_read", {16'h0, bus.Data_to_CPU}, 32'h0145);
    check("rw_both_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h40, 7'h40, 7'h0E, 7'h40});
    bus.MEM_WE = 1'b1; bus.MEM_OE = 1'b1;

    // full pause handshake
    bus.pause_req = 1'b1; bus.LED_val = 10'h2A5;
    tick(1);
    bus.LED_val = 10'h3FF;
    check("pause_led", {22'h0, LED}, 32'h2A5);
    Continue = 1'b0;
    tick(2);
    Continue = 1'b1;
    tick(10);
    check("short_pulse_ignored", {31'h0, bus.pause_done}, 32'h0);
    Continue = 1'b0;
    tick(10);
    check("press_no_ack", {31'h0, bus.pause_done}, 32'h0);
    Continue = 1'b1;
    tick(6);
    check("release_latency_early", {31'h0, bus.pause_done}, 32'h0);
    tick(1);
    check("release_ack", {31'h0, bus.pause_done}, 32'h1);
    tick(5);
    check("ack_held", {31'h0, bus.pause_done}, 32'h1);
    check("led_held", {22'h0, LED}, 32'h2A5);
    bus.pause_req = 1'b0;
    tick(1);
    check("ack_drop", {31'h0, bus.pause_done}, 32'h0);

    // abort from WAIT_PRESS (re-arming proves the return to IDLE)
    bus.pause_req = 1'b1; bus.LED_val = 10'h155;
    tick(1);
    check("rearm_led", {22'h0, LED}, 32'h155);
    bus.pause_req = 1'b0;
    tick(1);
    bus.pause_req = 1'b1; bus.LED_val = 10'h2A5;
    tick(1);
    check("rearm_after_abort", {22'h0, LED}, 32'h2A5);
    bus.pause_req = 1'b0; bus.LED_val = 10'h011;
    tick(4);
    check("abort_no_ack", {31'h0, bus.pause_done}, 32'h0);
    check("abort_led_kept", {22'h0, LED}, 32'h2A5);

    // Continue held before the request
    Continue = 1'b0;
    tick(10);
    bus.pause_req = 1'b1; bus.LED_val = 10'h0AA;
    tick(12);
    check("held_no_ack", {31'h0, bus.pause_done}, 32'h0);
    check("held_led", {22'h0, LED}, 32'h0AA);
    Continue = 1'b1;
    tick(6);
    check("held_release_early", {31'h0, bus.pause_done}, 32'h0);
    tick(1);
    check("held_release_ack", {31'h0, bus.pause_done}, 32'h1);
    bus.pause_req = 1'b0;
    tick(2);
    check("held_ack_drop", {31'h0, bus.pause_done}, 32'h0);

    // asynchronous reset in WAIT_RELEASE
    bus.pause_req = 1'b1; bus.LED_val = 10'h123;
    tick(1);
    Continue = 1'b0;
    tick(8);
    Reset_ah = 1'b1;
    #1;
    check("async_reset_led", {22'h0, LED}, 32'h0);
    check("async_reset_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});
    check("async_reset_done", {31'h0, bus.pause_done}, 32'h0);
    tick(1);
    Reset_ah = 1'b0;
    Continue = 1'b1;
    tick(1);
    check("post_reset_idle", {22'h0, LED}, 32'h123);
    bus.pause_req = 1'b0;
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
